// File: rtl/tcm_port_arb.sv
// TCM port arbiter: shares one SRAM port between the core (C) and a
// secondary master (D), with programmable wait-state occupancy.
module tcm_port_arb #(
  parameter int AW     = 13,
  parameter int DW     = 32,
  parameter int RDW    = 2,
  parameter int STARVE = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [RDW-1:0]  waitcyc,
  input  logic            c_cs,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW/8-1:0] c_we,
  input  logic [DW-1:0]   c_wd,
  output logic            c_wait,
  output logic            c_rvalid,
  output logic [DW-1:0]   c_rd,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW/8-1:0] d_we,
  input  logic [DW-1:0]   d_wd,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rd,
  output logic            ram_cs,
  output logic [AW-1:0]   ram_addr,
  output logic [DW/8-1:0] ram_we,
  output logic [DW-1:0]   ram_wd,
  input  logic [DW-1:0]   ram_rd,
  output logic            busy
);

  localparam int BW = DW / 8;
  localparam int NT = 1 << RDW;
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE);

  typedef enum logic {
    IDLE,
    OCC
  } state_e;

  state_e         state_q, state_d;
  logic [RDW-1:0] cnt_q, cnt_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [NT-1:0]  tag_vld_q, tag_vld_d;
  logic [NT-1:0]  tag_prt_q, tag_prt_d;

  logic          free;
  logic          d_win;
  logic          gnt_c;
  logic          gnt_d;
  logic          gnt_any;
  logic [BW-1:0] sel_we;
  logic          is_rd;

  assign free  = (state_q == IDLE) | (cnt_q == '0);
  assign d_win = d_req & (~c_cs | (starve_q == SMAX));

  // No grants while reset is asserted, so a held C request just waits.
  assign gnt_c   = resetn & free & c_cs & ~d_win;
  assign gnt_d   = resetn & free & d_win;
  assign gnt_any = gnt_c | gnt_d;

  assign c_wait = c_cs & ~gnt_c;
  assign d_gnt  = gnt_d;

  always_comb begin
    sel_we   = '0;
    ram_addr = '0;
    ram_wd   = '0;
    unique case (1'b1)
      gnt_d: begin
        sel_we   = d_we;
        ram_addr = d_addr;
        ram_wd   = d_wd;
      end
      gnt_c: begin
        sel_we   = c_we;
        ram_addr = c_addr;
        ram_wd   = c_wd;
      end
      default: ;
    endcase
  end

  assign ram_cs = gnt_any;
  assign ram_we = sel_we;
  assign is_rd  = gnt_any & (sel_we == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (gnt_any) begin
      cnt_d   = waitcyc;
      state_d = (waitcyc != '0) ? OCC : IDLE;
    end else if (state_q == OCC) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt_d | ~d_req) begin
      starve_d = '0;
    end else if (gnt_c && starve_q != SMAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Read tags enter at slot waitcyc and reach slot 0 when ram_rd is valid.
  always_comb begin
    tag_vld_d = tag_vld_q >> 1;
    tag_prt_d = tag_prt_q >> 1;
    if (is_rd) begin
      tag_vld_d[waitcyc] = 1'b1;
      tag_prt_d[waitcyc] = gnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      starve_q  <= '0;
      tag_vld_q <= '0;
      tag_prt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      tag_vld_q <= tag_vld_d;
      tag_prt_q <= tag_prt_d;
    end
  end

  assign c_rvalid = resetn & tag_vld_q[0] & ~tag_prt_q[0];
  assign d_rvalid = resetn & tag_vld_q[0] & tag_prt_q[0];
  assign c_rd     = c_rvalid ? ram_rd : '0;
  assign d_rd     = d_rvalid ? ram_rd : '0;
  assign busy     = resetn & (state_q == OCC) & (cnt_q != '0);

endmodule
